// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, synchronous-read 32-bit memory
// between the instruction-fetch (IF) port and the data (DM) port.
// The data port wins by default. A starvation counter forces an IF grant after
// STARVE_LIMIT consecutive denied IF cycles. Read data is routed to the port
// that owns the outstanding read, and the fetch stall is driven from the grant.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 IF read request and byte address
//   if_gnt/if_rvalid/if_rdata      IF grant (comb), response valid, response data
//   stall_if                       if_req & ~if_gnt
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata   DM request, write enable, byte enables, address, write data
//   dm_gnt/dm_rvalid/dm_rdata      DM grant (comb), response valid, response data
//   mem_addr/mem_we/mem_be/mem_wdata      memory word address and write controls
//   mem_rdata                      memory read data, valid 1 cycle after address
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    owner_e           r_owner;
    owner_e           w_owner_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_force_if;
    logic             w_if_gnt;
    logic             w_dm_gnt;
    logic             w_unused_lsbs;

    // Byte-lane address bits carry no meaning for a word-wide memory.
    assign w_unused_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

    // Grant: DM by default, IF when the starvation counter has saturated.
    assign w_force_if = if_req & (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign w_dm_gnt   = ~rst & dm_req & ~w_force_if;
    assign w_if_gnt   = ~rst & if_req & ~w_dm_gnt;
    assign if_gnt     = w_if_gnt;
    assign dm_gnt     = w_dm_gnt;
    assign stall_if   = if_req & ~w_if_gnt;

    // Starvation counter: counts denied IF cycles, saturating; clears otherwise.
    always_comb begin
        w_starve_nxt = '0;
        if (if_req & ~w_if_gnt) begin
            if (r_starve_cnt == CNT_W'(STARVE_LIMIT)) begin
                w_starve_nxt = r_starve_cnt;
            end else begin
                w_starve_nxt = r_starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Memory drive from whichever port holds the grant; idle parks at word 0.
    always_comb begin
        mem_addr = '0;
        if (w_if_gnt) begin
            mem_addr = if_addr[ADDR_W-1:2];
        end else if (w_dm_gnt) begin
            mem_addr = dm_addr[ADDR_W-1:2];
        end
        mem_we    = w_dm_gnt & dm_we;
        mem_be    = mem_we ? dm_be : 4'b0000;
        mem_wdata = dm_wdata;
    end

    // Response owner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // Response owner next-state and read-data routing. Reset masks an
    // in-flight read so no stale rvalid escapes during or after reset.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if_rvalid   = 1'b0;
        dm_rvalid   = 1'b0;
        if_rdata    = '0;
        dm_rdata    = '0;
        if (w_if_gnt) begin
            w_owner_nxt = OWN_IF;
        end else if (w_dm_gnt & ~dm_we) begin
            w_owner_nxt = OWN_DM;
        end
        if (!rst) begin
            case (r_owner)
                OWN_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                OWN_DM: begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a behavioural memory answers the
// DUT's memory port while a reference model derives expected grants, memory
// drive and read responses directly from the arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W       = 10;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned WORDS        = 256;
    localparam int          N_CYCLES     = 3000;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              stall_if;
    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .stall_if (stall_if),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_be    (dm_be),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B1 ^ 32'hA5A5_0000;
    endfunction

    // Behavioural single-port memory: byte-enabled write, registered read.
    logic        mem_init;
    logic [31:0] env_mem [WORDS];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < int'(WORDS); i++) env_mem[i] <= init_word(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= env_mem[mem_addr];
        end
    end

    int n_checks;
    int n_bad;
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [WORDS];
    int          m_cnt;
    int          m_own;      // 0 none, 1 IF, 2 DM
    logic [31:0] m_data;
    bit          g_if;
    bit          g_dm;

    task automatic step_model();
        bit          gi, gd, frc, e_we;
        logic [7:0]  e_addr;
        logic [3:0]  e_be;
        bit          ev_if, ev_dm;
        logic [7:0]  w;
        gi = 0; gd = 0;
        if (!rst) begin
            frc = if_req && (m_cnt == int'(STARVE_LIMIT));
            gd  = dm_req && !frc;
            gi  = if_req && !gd;
        end
        e_addr = gi ? if_addr[ADDR_W-1:2] : (gd ? dm_addr[ADDR_W-1:2] : 8'h00);
        e_we   = gd && dm_we;
        e_be   = e_we ? dm_be : 4'b0000;
        ev_if  = !rst && (m_own == 1);
        ev_dm  = !rst && (m_own == 2);

        check("if_gnt",    32'(if_gnt),    32'(gi));
        check("dm_gnt",    32'(dm_gnt),    32'(gd));
        check("stall_if",  32'(stall_if),  32'(if_req && !gi));
        check("mem_addr",  32'(mem_addr),  32'(e_addr));
        check("mem_we",    32'(mem_we),    32'(e_we));
        check("mem_be",    32'(mem_be),    32'(e_be));
        if (e_we) check("mem_wdata", mem_wdata, dm_wdata);
        check("if_rvalid", 32'(if_rvalid), 32'(ev_if));
        check("dm_rvalid", 32'(dm_rvalid), 32'(ev_dm));
        check("if_rdata",  if_rdata,       ev_if ? m_data : 32'h0);
        check("dm_rdata",  dm_rdata,       ev_dm ? m_data : 32'h0);

        // Advance the model by one cycle
        if (rst) begin
            m_cnt = 0;
            m_own = 0;
        end else begin
            if (if_req && !gi) m_cnt = (m_cnt < int'(STARVE_LIMIT)) ? m_cnt + 1 : m_cnt;
            else               m_cnt = 0;
            m_own = gi ? 1 : ((gd && !dm_we) ? 2 : 0);
            if (gi || gd) m_data = ref_mem[e_addr];
            if (e_we) begin
                w = e_addr;
                for (int b = 0; b < 4; b++)
                    if (dm_be[b]) ref_mem[w][8*b +: 8] = dm_wdata[8*b +: 8];
            end
        end
        g_if = gi;
        g_dm = gd;
    endtask

    // Mostly a small window of words so reads hit recent writes.
    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [7:0] word;
        word = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        return {word, 2'($urandom)};
    endfunction

    task automatic drive_next(input int c);
        int if_pct, dm_pct, ph;
        ph = c % 400;
        if (ph >= 100 && ph < 130) begin
            if_pct = 100; dm_pct = 100;
        end else if (ph >= 200 && ph < 220) begin
            if_pct = 0; dm_pct = 0;
        end else begin
            if_pct = 50; dm_pct = 60;
        end
        rst = (c < 4) ? 1'b1 : ($urandom_range(0, 59) == 0);

        if (if_req && !g_if && ($urandom_range(0, 15) != 0)) begin
            if_req = 1'b1;
        end else begin
            if_req  = (if_req && !g_if) ? 1'b0 : ($urandom_range(0, 99) < if_pct);
            if_addr = rand_addr();
        end

        if (dm_req && !g_dm && ($urandom_range(0, 15) != 0)) begin
            dm_req = 1'b1;
        end else begin
            dm_req   = (dm_req && !g_dm) ? 1'b0 : ($urandom_range(0, 99) < dm_pct);
            dm_addr  = rand_addr();
            dm_we    = ($urandom_range(0, 99) < 40);
            dm_be    = 4'($urandom);
            dm_wdata = $urandom;
        end
        if (c < 4) begin
            if_req = 1'b0;
            dm_req = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        cyc      = 0;
        rst      = 1'b1;
        mem_init = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_be    = 4'b0000;
        dm_addr  = '0;
        dm_wdata = '0;
        m_cnt    = 0;
        m_own    = 0;
        m_data   = '0;
        g_if     = 0;
        g_dm     = 0;
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_word(i);

        for (int c = 0; c < N_CYCLES; c++) begin
            cyc = c;
            @(negedge clk);
            step_model();
            @(posedge clk);
            #1;
            if (c >= 1) mem_init = 1'b0;
            drive_next(c + 1);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
